// File: rtl/sc_core_oz_rf_wb.sv
// sc_core_oz_rf_wb: write-back stage and 32x32 integer register file for the
// single-cycle RV32I core. Two combinational operand read ports (rs1/rs2), a
// debug read port, a retired-write counter and the last committed index.
// Optional build macro SC_CORE_OZ_RF_BYPASS_EN: a read port addressing the
// register being committed returns wb_data in the same cycle instead of the
// pre-commit contents.
module sc_core_oz_rf_wb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned CNT_W    = 32,
    localparam int unsigned AW      = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data,
    output logic [CNT_W-1:0] wb_cnt,
    output logic [AW-1:0]   wb_last_rd
);

    // Flat array so a single reset edge can clear every register.
    logic [XLEN-1:0]  r_regs [NUM_REGS];
    logic [CNT_W-1:0] r_wb_cnt;
    logic [AW-1:0]    r_wb_last_rd;
    logic             w_commit;

    assign w_commit = wb_en && (wb_rd != '0);

    // Read-port select: x0 is hard-wired to zero; optional same-cycle bypass.
    function automatic logic [XLEN-1:0] f_read(input logic [AW-1:0] a,
                                               input logic [XLEN-1:0] stored);
        logic [XLEN-1:0] v;
        if (a == '0) begin
            v = '0;
        end else begin
`ifdef SC_CORE_OZ_RF_BYPASS_EN
            if (w_commit && (a == wb_rd)) begin
                v = wb_data;
            end else begin
                v = stored;
            end
`else
            v = stored;
`endif
        end
        return v;
    endfunction

    // Register file, commit counter and last-index update; reset overrides commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wb_cnt     <= '0;
            r_wb_last_rd <= '0;
        end else if (w_commit) begin
            r_regs[wb_rd] <= wb_data;
            r_wb_cnt      <= r_wb_cnt + CNT_W'(1);
            r_wb_last_rd  <= wb_rd;
        end
    end

    // Three independent combinational read ports.
    always_comb begin
        rs1_data = f_read(rs1_addr, r_regs[rs1_addr]);
        rs2_data = f_read(rs2_addr, r_regs[rs2_addr]);
        dbg_data = f_read(dbg_addr, r_regs[dbg_addr]);
    end

    assign wb_cnt     = r_wb_cnt;
    assign wb_last_rd = r_wb_last_rd;

endmodule

// File: tb/tb_sc_core_oz_rf_wb.sv
// Directed testbench for sc_core_oz_rf_wb (both build variants of
// SC_CORE_OZ_RF_BYPASS_EN select the matching same-cycle expectation).
module tb_sc_core_oz_rf_wb;

    logic        clk;
    logic        rst;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [31:0] wb_cnt;
    logic [4:0]  wb_last_rd;

    int unsigned n_tests;
    int unsigned n_fail;
    logic [31:0] pre [32];
    logic [31:0] exp_same;

    sc_core_oz_rf_wb #(.XLEN(32), .NUM_REGS(32), .CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .wb_cnt     (wb_cnt),
        .wb_last_rd (wb_last_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of write-back inputs and reset, then sample #1 after the edge.
    task automatic cycle(input logic r, input logic en, input logic [4:0] rd,
                         input logic [31:0] d);
        @(negedge clk);
        rst = r; wb_en = en; wb_rd = rd; wb_data = d;
        @(posedge clk);
        #1;
        rst = 1'b0; wb_en = 1'b0;
    endtask

    task automatic rd_all(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
        rs1_addr = a1; rs2_addr = a2; dbg_addr = ad;
        #1;
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        rs1_addr = '0; rs2_addr = '0; dbg_addr = '0;
        cycle(1'b1, 1'b0, 5'd0, 32'h0);

        // Random preload of x1..x31
        for (int i = 1; i < 32; i++) begin
            pre[i] = $urandom;
            cycle(1'b0, 1'b1, 5'(i), pre[i]);
        end
        chk("preload_cnt", wb_cnt, 32'd31);
        chk("preload_last", {27'b0, wb_last_rd}, 32'd31);
        rd_all(5'd1, 5'd17, 5'd31);
        chk("preload_x1", rs1_data, pre[1]);
        chk("preload_x17", rs2_data, pre[17]);
        chk("preload_x31", dbg_data, pre[31]);

        // Test 1: reset clears everything
        cycle(1'b1, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 32; i++) begin
            rd_all(5'd0, 5'd0, 5'(i));
            chk($sformatf("reset_x%0d", i), dbg_data, 32'h0);
        end
        chk("reset_cnt", wb_cnt, 32'h0);
        chk("reset_last", {27'b0, wb_last_rd}, 32'h0);

        // Test 2: commit x5
        cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
        rd_all(5'd5, 5'd5, 5'd5);
        chk("t2_rs1", rs1_data, 32'hDEADBEEF);
        chk("t2_rs2", rs2_data, 32'hDEADBEEF);
        chk("t2_dbg", dbg_data, 32'hDEADBEEF);
        chk("t2_cnt", wb_cnt, 32'd1);
        chk("t2_last", {27'b0, wb_last_rd}, 32'd5);

        // Test 3: write to x0 discarded
        cycle(1'b0, 1'b1, 5'd0, 32'h12345678);
        rd_all(5'd0, 5'd0, 5'd0);
        chk("t3_rs1_x0", rs1_data, 32'h0);
        chk("t3_dbg_x0", dbg_data, 32'h0);
        chk("t3_cnt", wb_cnt, 32'd1);
        chk("t3_last", {27'b0, wb_last_rd}, 32'd5);

        // wb_en=0 leaves state alone
        cycle(1'b0, 1'b0, 5'd9, 32'hCAFEF00D);
        rd_all(5'd9, 5'd5, 5'd9);
        chk("noen_x9", rs1_data, 32'h0);
        chk("noen_x5", rs2_data, 32'hDEADBEEF);
        chk("noen_cnt", wb_cnt, 32'd1);

        // Test 4: same-cycle read of the register being written
        cycle(1'b0, 1'b1, 5'd7, 32'h11);
        @(negedge clk);
        wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h22;
        rs1_addr = 5'd7; rs2_addr = 5'd5; dbg_addr = 5'd7;
        #1;
`ifdef SC_CORE_OZ_RF_BYPASS_EN
        exp_same = 32'h22;
`else
        exp_same = 32'h11;
`endif
        chk("t4_rs1_same", rs1_data, exp_same);
        chk("t4_dbg_same", dbg_data, exp_same);
        chk("t4_rs2_other", rs2_data, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        wb_en = 1'b0;
        chk("t4_rs1_next", rs1_data, 32'h22);
        chk("t4_cnt", wb_cnt, 32'd3);
        chk("t4_last", {27'b0, wb_last_rd}, 32'd7);

        // x31 upper boundary
        cycle(1'b0, 1'b1, 5'd31, 32'hA5A5_5A5A);
        rd_all(5'd31, 5'd31, 5'd7);
        chk("x31_rs1", rs1_data, 32'hA5A5_5A5A);
        chk("x31_rs2", rs2_data, 32'hA5A5_5A5A);
        chk("x31_dbg_x7", dbg_data, 32'h22);
        chk("x31_cnt", wb_cnt, 32'd4);

        // Test 5: counter wrap
        @(negedge clk);
        force dut.r_wb_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_wb_cnt;
        #1;
        chk("t5_cnt_max", wb_cnt, 32'hFFFF_FFFF);
        cycle(1'b0, 1'b1, 5'd3, 32'h0000_0333);
        rd_all(5'd3, 5'd0, 5'd3);
        chk("t5_cnt_wrap", wb_cnt, 32'h0);
        chk("t5_x3", rs1_data, 32'h0000_0333);
        chk("t5_last", {27'b0, wb_last_rd}, 32'd3);
        cycle(1'b0, 1'b1, 5'd4, 32'h4);
        chk("t5_cnt_after", wb_cnt, 32'd1);

        // Test 6: reset wins over a simultaneous commit
        cycle(1'b1, 1'b1, 5'd9, 32'hAA);
        rd_all(5'd9, 5'd5, 5'd3);
        chk("t6_x9", rs1_data, 32'h0);
        chk("t6_x5", rs2_data, 32'h0);
        chk("t6_x3", dbg_data, 32'h0);
        chk("t6_cnt", wb_cnt, 32'h0);
        chk("t6_last", {27'b0, wb_last_rd}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
